// File: rtl/exception_unit_if.sv
// Signal bundle between the pipeline/cp0 and the MEM-stage exception arbiter.
// The driver side (pipeline, cp0, bench) uses master; the arbiter uses slave.
interface exception_unit_if;
    logic [5:0]  int_i;
    logic [5:0]  int_sync_o;
    logic [31:0] mem_pc_i;
    logic        mem_dslot_i;
    logic [31:0] mem_addr_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_dslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output int_i, mem_pc_i, mem_dslot_i, mem_addr_i, exc_flags_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  int_sync_o, excepttype_o, exc_pc_o, exc_dslot_o,
               bad_addr_o, flush_o, new_pc_o
    );

    modport slave (
        input  int_i, mem_pc_i, mem_dslot_i, mem_addr_i, exc_flags_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output int_sync_o, excepttype_o, exc_pc_o, exc_dslot_o,
               bad_addr_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/exception_unit.sv
// MEM-stage exception arbiter: picks the highest-priority exception, hands it to cp0,
// pulses a one-cycle flush with the redirect PC, then ignores the draining bubbles.
module exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input logic             clk,
    input logic             rst,
    exception_unit_if.slave bus
);
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN} state_t;

    state_t                          r_state, w_nstate;
    logic [CW-1:0]                   r_cnt, w_ncnt;
    logic [SYNC_STAGES-1:0][5:0]     r_sync;
    logic [31:0]                     r_code, r_pc, r_bad, r_newpc;
    logic                            r_dslot, r_flush;
    logic [31:0]                     w_ncode, w_npc, w_nbad, w_nnewpc;
    logic                            w_ndslot, w_nflush;
    logic [31:0]                     w_status, w_cause, w_epc;
    logic                            w_int, w_det;
    logic [31:0]                     w_code, w_bad;

    // Flag vector layout: {eret,ades,adel_d,brk,sys,trap,ov,ri,adel_f}
    logic [8:0] w_f;
    assign w_f = bus.exc_flags_i;

    always_ff @(posedge clk) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.int_i};
    end

    // Forward an mtc0 still sitting in WB so this cycle's decision sees it.
    always_comb begin
        w_status = bus.cp0_status_i;
        w_cause  = bus.cp0_cause_i;
        w_epc    = bus.cp0_epc_i;
        if (bus.wb_cp0_we_i) begin
            case (bus.wb_cp0_waddr_i)
                5'd12:   w_status = bus.wb_cp0_data_i;
                5'd13:   w_cause[9:8] = bus.wb_cp0_data_i[9:8];
                5'd14:   w_epc = bus.wb_cp0_data_i;
                default: ;
            endcase
        end
    end

    assign w_int = w_status[0] && !w_status[1] &&
                   ((w_cause[15:8] & w_status[15:8]) != 8'h00) &&
                   (bus.mem_pc_i != 32'h0);

    always_comb begin
        w_code = 32'h0;
        w_bad  = 32'h0;
        if      (w_int)  w_code = 32'h01;
        else if (w_f[0]) begin w_code = 32'h04; w_bad = bus.mem_pc_i;   end
        else if (w_f[1]) w_code = 32'h0a;
        else if (w_f[2]) w_code = 32'h0c;
        else if (w_f[3]) w_code = 32'h0d;
        else if (w_f[4]) w_code = 32'h08;
        else if (w_f[5]) w_code = 32'h09;
        else if (w_f[6]) begin w_code = 32'h04; w_bad = bus.mem_addr_i; end
        else if (w_f[7]) begin w_code = 32'h05; w_bad = bus.mem_addr_i; end
        else if (w_f[8]) w_code = 32'h0e;
    end

    assign w_det = (bus.mem_pc_i != 32'h0) && (w_int || (w_f != 9'h0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
            r_pc    <= '0;
            r_dslot <= 1'b0;
            r_bad   <= '0;
            r_flush <= 1'b0;
            r_newpc <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_code  <= w_ncode;
            r_pc    <= w_npc;
            r_dslot <= w_ndslot;
            r_bad   <= w_nbad;
            r_flush <= w_nflush;
            r_newpc <= w_nnewpc;
        end
    end

    // Output registers are loaded only on the detect edge, so they hold data for the FLUSH cycle alone.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_ncode  = 32'h0;
        w_npc    = 32'h0;
        w_ndslot = 1'b0;
        w_nbad   = 32'h0;
        w_nflush = 1'b0;
        w_nnewpc = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_det) begin
                    w_nstate = S_FLUSH;
                    w_ncode  = w_code;
                    w_npc    = bus.mem_pc_i;
                    w_ndslot = bus.mem_dslot_i;
                    w_nbad   = w_bad;
                    w_nflush = 1'b1;
                    w_nnewpc = (w_code == 32'h0e) ? w_epc : EXC_VECTOR;
                end
            end
            S_FLUSH: begin
                w_nstate = S_DRAIN;
                w_ncnt   = '0;
            end
            S_DRAIN: begin
                if (r_cnt == LAST_CNT) w_nstate = S_IDLE;
                else                   w_ncnt   = r_cnt + CW'(1);
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    assign bus.int_sync_o   = r_sync[SYNC_STAGES-1];
    assign bus.excepttype_o = r_code;
    assign bus.exc_pc_o     = r_pc;
    assign bus.exc_dslot_o  = r_dslot;
    assign bus.bad_addr_o   = r_bad;
    assign bus.flush_o      = r_flush;
    assign bus.new_pc_o     = r_newpc;
endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: reset, priority, forwarding, interrupts, drain masking, reset abort.
module tb_exception_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;

    exception_unit_if bus ();

    exception_unit #(
        .EXC_VECTOR  (32'hBFC00380),
        .DRAIN_CYCLES(2),
        .SYNC_STAGES (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.int_i          = 6'h0;
        bus.mem_pc_i       = 32'h0;
        bus.mem_dslot_i    = 1'b0;
        bus.mem_addr_i     = 32'h0;
        bus.exc_flags_i    = 9'h0;
        bus.cp0_status_i   = 32'h0;
        bus.cp0_cause_i    = 32'h0;
        bus.cp0_epc_i      = 32'h0;
        bus.wb_cp0_we_i    = 1'b0;
        bus.wb_cp0_waddr_i = 5'h0;
        bus.wb_cp0_data_i  = 32'h0;
    endtask

    // Clear inputs and let FLUSH + DRAIN run out.
    task automatic drain();
        idle_in();
        repeat (4) step();
    endtask

    task automatic chk_exc(input string tag, input logic [31:0] code, input logic [31:0] pc,
                           input logic dslot, input logic [31:0] bad, input logic [31:0] npc);
        chk({tag, ".flush"}, {31'h0, bus.flush_o}, 32'h1);
        chk({tag, ".code"},  bus.excepttype_o, code);
        chk({tag, ".pc"},    bus.exc_pc_o, pc);
        chk({tag, ".dslot"}, {31'h0, bus.exc_dslot_o}, {31'h0, dslot});
        chk({tag, ".bad"},   bus.bad_addr_o, bad);
        chk({tag, ".newpc"}, bus.new_pc_o, npc);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".flush"}, {31'h0, bus.flush_o}, 32'h0);
        chk({tag, ".code"},  bus.excepttype_o, 32'h0);
        chk({tag, ".newpc"}, bus.new_pc_o, 32'h0);
    endtask

    initial begin
        idle_in();
        // Reset held with a live syscall in MEM
        rst = 1'b0;
        bus.mem_pc_i    = 32'hBFC00100;
        bus.exc_flags_i = 9'h010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet("rst");
            chk("rst.sync", {26'h0, bus.int_sync_o}, 32'h0);
        end
        idle_in();
        rst = 1'b1;
        step();
        chk_quiet("post_rst");

        // Syscall held high: flush once, masked through FLUSH+2 DRAIN, then detected again
        bus.mem_pc_i    = 32'hBFC00100;
        bus.exc_flags_i = 9'h010;
        step();
        chk_exc("sys", 32'h08, 32'hBFC00100, 1'b0, 32'h0, 32'hBFC00380);
        step();
        chk_quiet("sys.fall");
        chk("sys.pc0", bus.exc_pc_o, 32'h0);
        step();
        chk_quiet("sys.drain1");
        step();
        chk_quiet("sys.drain2");
        step();
        chk_exc("sys.again", 32'h08, 32'hBFC00100, 1'b0, 32'h0, 32'hBFC00380);
        drain();

        // Priority: ov beats adel_d; adel_d alone reports data address
        bus.mem_pc_i    = 32'h80001000;
        bus.mem_addr_i  = 32'h80000003;
        bus.exc_flags_i = 9'h044;
        bus.mem_dslot_i = 1'b1;
        step();
        chk_exc("ov", 32'h0c, 32'h80001000, 1'b1, 32'h0, 32'hBFC00380);
        drain();
        bus.mem_pc_i    = 32'h80001000;
        bus.mem_addr_i  = 32'h80000003;
        bus.exc_flags_i = 9'h040;
        step();
        chk_exc("adel_d", 32'h04, 32'h80001000, 1'b0, 32'h80000003, 32'hBFC00380);
        drain();
        // adel_f beats ades; bad address is the PC
        bus.mem_pc_i    = 32'h80001001;
        bus.mem_addr_i  = 32'h80000007;
        bus.exc_flags_i = 9'h081;
        step();
        chk_exc("adel_f", 32'h04, 32'h80001001, 1'b0, 32'h80001001, 32'hBFC00380);
        drain();
        bus.mem_pc_i    = 32'h80001004;
        bus.mem_addr_i  = 32'h80000006;
        bus.exc_flags_i = 9'h180;
        step();
        chk_exc("ades", 32'h05, 32'h80001004, 1'b0, 32'h80000006, 32'hBFC00380);
        drain();

        // Bubble with flags set: no exception
        bus.exc_flags_i = 9'h010;
        step();
        chk_quiet("bubble");
        drain();

        // ERET with same-cycle forwarded EPC
        bus.mem_pc_i       = 32'h80003000;
        bus.cp0_epc_i      = 32'h00000100;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd14;
        bus.wb_cp0_data_i  = 32'hBFC00200;
        bus.exc_flags_i    = 9'h100;
        step();
        chk_exc("eret", 32'h0e, 32'h80003000, 1'b0, 32'h0, 32'hBFC00200);
        drain();

        // Interrupt synchroniser latency
        bus.cp0_status_i = 32'h0000FF01;
        bus.int_i        = 6'h01;
        step();
        chk("sync.e1", {26'h0, bus.int_sync_o}, 32'h0);
        step();
        chk("sync.e2", {26'h0, bus.int_sync_o}, 32'h1);
        chk_quiet("sync.noexc");
        // Hardware interrupt beats syscall
        bus.cp0_cause_i = 32'h00000400;
        bus.mem_pc_i    = 32'h80004000;
        bus.exc_flags_i = 9'h010;
        step();
        chk_exc("int", 32'h01, 32'h80004000, 1'b0, 32'h0, 32'hBFC00380);
        drain();
        // Same interrupt masked by a forwarded status write of 0
        bus.cp0_status_i   = 32'h0000FF01;
        bus.cp0_cause_i    = 32'h00000400;
        bus.mem_pc_i       = 32'h80004000;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd12;
        bus.wb_cp0_data_i  = 32'h0;
        step();
        chk_quiet("int.masked");
        // EXL set masks too
        bus.wb_cp0_we_i  = 1'b0;
        bus.cp0_status_i = 32'h0000FF03;
        step();
        chk_quiet("int.exl");
        // Software interrupt via forwarded cause write
        bus.cp0_status_i   = 32'h0000FF01;
        bus.cp0_cause_i    = 32'h0;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd13;
        bus.wb_cp0_data_i  = 32'h00000100;
        step();
        chk_exc("swint", 32'h01, 32'h80004000, 1'b0, 32'h0, 32'hBFC00380);
        drain();

        // Reset during FLUSH aborts; FSM restarts in IDLE
        bus.mem_pc_i    = 32'h80005000;
        bus.exc_flags_i = 9'h020;
        step();
        chk_exc("brk", 32'h09, 32'h80005000, 1'b0, 32'h0, 32'hBFC00380);
        rst = 1'b0;
        step();
        chk_quiet("abort");
        rst = 1'b1;
        step();
        chk_exc("abort.idle", 32'h09, 32'h80005000, 1'b0, 32'h0, 32'hBFC00380);
        drain();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
